// File: rtl/dtree_sched_pkg.sv
// Shared types, default widths and helpers for the decision-tree evaluation scheduler.
package dtree_sched_pkg;

  localparam int unsigned FEAT_W_DEF = 8;
  localparam int unsigned CLS_W_DEF  = 1;
  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned SETTLE_W   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  // Increment that sticks at max_v instead of wrapping; counters up to 32 bits.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v == max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dtree_class_hist.sv
// Per-class saturating result counters, bumped on every accepted result.
module dtree_class_hist
  import dtree_sched_pkg::*;
#(
  parameter int unsigned CLS_W = CLS_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           hist_clr,
  input  logic                           hs,
  input  logic [CLS_W-1:0]               cls,
  output logic [(2**CLS_W)*CNT_W-1:0]    class_hist
);

  localparam int unsigned NUM_CLS = 2**CLS_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [NUM_CLS];

  // Counter bank; a clear request overrides a coincident handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_CLS); i++) cnt_q[i] <= '0;
    end else if (hist_clr) begin
      for (int i = 0; i < int'(NUM_CLS); i++) cnt_q[i] <= '0;
    end else if (hs) begin
      cnt_q[cls] <= CNT_W'(sat_inc(32'(cnt_q[cls]), 32'(CNT_MAX)));
    end
  end

  for (genvar g = 0; g < int'(NUM_CLS); g++) begin : g_flat
    assign class_hist[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule

// File: rtl/dtree_eval_sched.sv
// Feeds samples to an external combinational decision tree, holds its inputs for a
// settle window, then captures the class and offers it to a valid/ready sink.
// Optional per-class histogram: define DTREE_CLASS_HIST_EN.
module dtree_eval_sched
  import dtree_sched_pkg::*;
#(
  parameter int unsigned FEAT_W        = FEAT_W_DEF,
  parameter int unsigned NUM_FEAT      = 1,
  parameter int unsigned CLS_W         = CLS_W_DEF,
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [NUM_FEAT*FEAT_W-1:0]   in_data,
  output logic                         in_ready,
  output logic [NUM_FEAT*FEAT_W-1:0]   tree_x,
  input  logic [CLS_W-1:0]             tree_class,
  output logic                         out_valid,
  output logic [CLS_W-1:0]             out_class,
  input  logic                         out_ready,
  output logic                         busy,
  output logic [CNT_W-1:0]             sample_cnt
`ifdef DTREE_CLASS_HIST_EN
  ,
  input  logic                         hist_clr,
  output logic [(2**CLS_W)*CNT_W-1:0]  class_hist
`endif
);

  localparam int unsigned X_W = NUM_FEAT * FEAT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

  state_e              state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [X_W-1:0]      tree_x_d;
  logic [CLS_W-1:0]    out_class_d;
  logic                out_valid_d;
  logic [CNT_W-1:0]    cnt_d;
  logic                hs_c;

  // Ready depends only on state and, while holding a result, on the sink.
  assign in_ready = (state_q == IDLE) || ((state_q == HOLD) && out_ready);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      settle_q   <= '0;
      tree_x     <= '0;
      out_class  <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      sample_cnt <= '0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      tree_x     <= tree_x_d;
      out_class  <= out_class_d;
      out_valid  <= out_valid_d;
      busy       <= (state_d != IDLE);
      sample_cnt <= cnt_d;
    end
  end

  // Next-state logic: accept, count down the settle window, capture, hand off.
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    tree_x_d    = tree_x;
    out_class_d = out_class;
    out_valid_d = out_valid;
    cnt_d       = sample_cnt;
    hs_c        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          tree_x_d = in_data;
          settle_d = SETTLE_LOAD;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_q == '0) begin
          out_class_d = tree_class;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          settle_d = settle_q - SETTLE_W'(1);
        end
      end
      HOLD: begin
        if (out_ready) begin
          hs_c        = 1'b1;
          cnt_d       = CNT_W'(sat_inc(32'(sample_cnt), 32'(CNT_MAX)));
          out_valid_d = 1'b0;
          if (in_valid) begin
            tree_x_d = in_data;
            settle_d = SETTLE_LOAD;
            state_d  = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

`ifdef DTREE_CLASS_HIST_EN
  dtree_class_hist #(
    .CLS_W (CLS_W),
    .CNT_W (CNT_W)
  ) u_hist (
    .clk        (clk),
    .rst_n      (rst_n),
    .hist_clr   (hist_clr),
    .hs         (hs_c),
    .cls        (out_class),
    .class_hist (class_hist)
  );
`endif

endmodule
